qlearn_agent: RTL and testbench

QLEARN_AGENT -- requirements
Module: qlearn_agent

---
 rtl/qlearn_agent.sv | 182 ++++++++++++++++++
 tb/tb_qlearn_agent.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_agent.sv
// Tabular Q-learning jump/no-jump agent with epsilon-greedy exploration.
// Q table is a single-port RAM of [sector][type] words holding both action values.
module qlearn_agent #(
   parameter int N_SECT     = 32,
   parameter int N_TYPE     = 4,
   parameter int Q_W        = 8,
   parameter int DIST_W     = 10,
   parameter int SECT_SHIFT = 5,
   parameter int ALPHA_SH   = 2,
   parameter int EPS_INIT   = 16,
   parameter int EPS_PERIOD = 1000000,
   localparam int TYPE_W    = (N_TYPE > 1) ? $clog2(N_TYPE) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              obs_valid,
   output logic              obs_ready,
   input  logic [DIST_W-1:0] obs_distance,
   input  logic [TYPE_W-1:0] obs_type,
   output logic              act_valid,
   output logic              act_jump,
   output logic              act_explore,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [DIST_W-1:0] upd_distance,
   input  logic [TYPE_W-1:0] upd_type,
   input  logic              upd_action,
   input  logic              upd_good,
   output logic [7:0]        epsilon,
   output logic              busy
);

   localparam int DEPTH  = N_SECT * N_TYPE;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (EPS_PERIOD > 1) ? $clog2(EPS_PERIOD) : 1;
   localparam logic [Q_W-1:0] Q_MID = {1'b1, {(Q_W-1){1'b0}}};
   localparam logic [Q_W-1:0] Q_MAX = {Q_W{1'b1}};

   typedef enum logic [2:0] {
      INIT, IDLE, OBS_RD, OBS_DEC, UPD_RD, UPD_WR
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   init_idx;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_act;
   logic                req_good;
   logic [2*Q_W-1:0]    qtab [DEPTH];
   logic [2*Q_W-1:0]    rd_q;
   logic                mem_we;
   logic                mem_re;
   logic [ADDR_W-1:0]   mem_addr;
   logic [2*Q_W-1:0]    mem_wdata;
   logic [Q_W-1:0]      q_hi, q_lo, q_old, q_new;
   logic [15:0]         lfsr;
   logic [CNT_W-1:0]    eps_cnt;
   logic                explore;

   function automatic logic [ADDR_W-1:0] to_addr(
      input logic [DIST_W-1:0] d,
      input logic [TYPE_W-1:0] t
   );
      logic [DIST_W-1:0] s;
      logic [TYPE_W-1:0] ty;
      s  = d >> SECT_SHIFT;
      ty = t;
      if (s > DIST_W'(N_SECT - 1))
         s = DIST_W'(N_SECT - 1);
      if ({1'b0, t} > (TYPE_W+1)'(N_TYPE - 1))
         ty = TYPE_W'(N_TYPE - 1);
      return ADDR_W'(s) * ADDR_W'(N_TYPE) + ADDR_W'(ty);
   endfunction

   assign q_hi  = rd_q[2*Q_W-1:Q_W];
   assign q_lo  = rd_q[Q_W-1:0];
   assign q_old = req_act ? q_hi : q_lo;
   // Shifted step shrinks toward the bound, so neither direction can wrap.
   assign q_new = req_good ? q_old + ((Q_MAX - q_old) >> ALPHA_SH)
                           : q_old - (q_old >> ALPHA_SH);
   assign explore = epsilon > lfsr[7:0];

   assign busy      = (state_q == INIT);
   assign upd_ready = (state_q == IDLE);
   assign obs_ready = (state_q == IDLE) && !upd_valid;

   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = req_addr;
      mem_wdata = {Q_MID, Q_MID};
      unique case (state_q)
         INIT: begin
            mem_we   = 1'b1;
            mem_addr = init_idx;
            if (init_idx == ADDR_W'(DEPTH - 1))
               state_d = IDLE;
         end
         IDLE: begin
            if (upd_valid)
               state_d = UPD_RD;
            else if (obs_valid)
               state_d = OBS_RD;
         end
         OBS_RD: begin
            mem_re  = 1'b1;
            state_d = OBS_DEC;
         end
         OBS_DEC: state_d = IDLE;
         UPD_RD: begin
            mem_re  = 1'b1;
            state_d = UPD_WR;
         end
         UPD_WR: begin
            mem_we    = 1'b1;
            mem_wdata = req_act ? {q_new, q_lo} : {q_hi, q_new};
            state_d   = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset)
         qtab[mem_addr] <= mem_wdata;
      if (mem_re)
         rd_q <= qtab[mem_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= INIT;
         init_idx    <= '0;
         req_addr    <= '0;
         req_act     <= 1'b0;
         req_good    <= 1'b0;
         act_valid   <= 1'b0;
         act_jump    <= 1'b0;
         act_explore <= 1'b0;
      end else begin
         state_q   <= state_d;
         act_valid <= 1'b0;
         if (state_q == INIT)
            init_idx <= init_idx + 1'b1;
         if (state_q == IDLE) begin
            if (upd_valid) begin
               req_addr <= to_addr(upd_distance, upd_type);
               req_act  <= upd_action;
               req_good <= upd_good;
            end else if (obs_valid) begin
               req_addr <= to_addr(obs_distance, obs_type);
            end
         end
         if (state_q == OBS_DEC) begin
            act_valid   <= 1'b1;
            act_explore <= explore;
            act_jump    <= explore ? lfsr[15] : (q_hi > q_lo);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 16'hACE1;
      else
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         epsilon <= 8'(EPS_INIT);
         eps_cnt <= '0;
      end else if (eps_cnt == CNT_W'(EPS_PERIOD - 1)) begin
         eps_cnt <= '0;
         if (epsilon != 8'd0)
            epsilon <= epsilon - 8'd1;
      end else begin
         eps_cnt <= eps_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_qlearn_agent.sv
// Directed bench for qlearn_agent: three instances share stimulus
// (greedy, fast epsilon decay, always-explore).
module tb_qlearn_agent;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       obs_valid = 1'b0;
   logic [9:0] obs_distance = '0;
   logic [1:0] obs_type = '0;
   logic       upd_valid = 1'b0;
   logic [9:0] upd_distance = '0;
   logic [1:0] upd_type = '0;
   logic       upd_action = 1'b0;
   logic       upd_good = 1'b0;

   logic       a_obs_ready, a_act_valid, a_act_jump, a_act_explore;
   logic       a_upd_ready, a_busy;
   logic [7:0] a_epsilon;
   logic       b_obs_ready, b_act_valid, b_act_jump, b_act_explore;
   logic       b_upd_ready, b_busy;
   logic [7:0] b_epsilon;
   logic       c_obs_ready, c_act_valid, c_act_jump, c_act_explore;
   logic       c_upd_ready, c_busy;
   logic [7:0] c_epsilon;

   int checks = 0;
   int failures = 0;

   logic [15:0] lfsr_m, lfsr_prev;
   logic [7:0]  bad_exp [12] = '{31, 24, 18, 14, 11, 9, 7, 6, 5, 4, 3, 3};
   logic [7:0]  good_exp [15] = '{183, 201, 214, 224, 231, 237, 241, 244,
                                  246, 248, 249, 250, 251, 252, 252};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset)
         lfsr_m <= 16'hACE1;
      else
         lfsr_m <= {lfsr_m[14:0],
                    lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      lfsr_prev <= lfsr_m;
   end

   qlearn_agent #(.EPS_INIT(0)) dut_a (
      .clk(clk), .reset(reset),
      .obs_valid(obs_valid), .obs_ready(a_obs_ready),
      .obs_distance(obs_distance), .obs_type(obs_type),
      .act_valid(a_act_valid), .act_jump(a_act_jump),
      .act_explore(a_act_explore),
      .upd_valid(upd_valid), .upd_ready(a_upd_ready),
      .upd_distance(upd_distance), .upd_type(upd_type),
      .upd_action(upd_action), .upd_good(upd_good),
      .epsilon(a_epsilon), .busy(a_busy)
   );

   qlearn_agent #(.EPS_INIT(2), .EPS_PERIOD(4)) dut_b (
      .clk(clk), .reset(reset),
      .obs_valid(obs_valid), .obs_ready(b_obs_ready),
      .obs_distance(obs_distance), .obs_type(obs_type),
      .act_valid(b_act_valid), .act_jump(b_act_jump),
      .act_explore(b_act_explore),
      .upd_valid(upd_valid), .upd_ready(b_upd_ready),
      .upd_distance(upd_distance), .upd_type(upd_type),
      .upd_action(upd_action), .upd_good(upd_good),
      .epsilon(b_epsilon), .busy(b_busy)
   );

   qlearn_agent #(.EPS_INIT(255)) dut_c (
      .clk(clk), .reset(reset),
      .obs_valid(obs_valid), .obs_ready(c_obs_ready),
      .obs_distance(obs_distance), .obs_type(obs_type),
      .act_valid(c_act_valid), .act_jump(c_act_jump),
      .act_explore(c_act_explore),
      .upd_valid(upd_valid), .upd_ready(c_upd_ready),
      .upd_distance(upd_distance), .upd_type(upd_type),
      .upd_action(upd_action), .upd_good(upd_good),
      .epsilon(c_epsilon), .busy(c_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (a_busy && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (a_busy !== 1'b0) begin
         failures++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0",
                  a_busy, n);
      end
   endtask

   task automatic table_all_mid(input string name);
      int bad = 0;
      for (int i = 0; i < 128; i++)
         if (dut_a.qtab[i] !== 16'h8080)
            bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s: %0d entries differ from 128/128, required 0",
                  name, bad);
      end
   endtask

   task automatic do_update(input logic [9:0] d, input logic [1:0] t,
                            input logic a, input logic g);
      int n = 0;
      while (!a_upd_ready && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (a_upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL upd_wait: upd_ready=%b, required 1", a_upd_ready);
      end
      upd_valid = 1'b1;
      upd_distance = d;
      upd_type = t;
      upd_action = a;
      upd_good = g;
      tick();
      upd_valid = 1'b0;
      upd_distance = ~d;
      upd_action = ~a;
      upd_good = ~g;
      tick();
      tick();
   endtask

   task automatic do_observe(input logic [9:0] d, input logic [1:0] t,
                             output int lat, output logic jmp,
                             output logic exp, output logic cj,
                             output logic cexp, output logic [15:0] lf,
                             output logic extra);
      int n = 0;
      while (!a_obs_ready && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (a_obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL obs_wait: obs_ready=%b, required 1", a_obs_ready);
      end
      obs_valid = 1'b1;
      obs_distance = d;
      obs_type = t;
      tick();
      obs_valid = 1'b0;
      obs_distance = ~d;
      obs_type = ~t;
      lat = 0;
      while (!a_act_valid && lat < 10) begin
         tick();
         lat++;
      end
      jmp = a_act_jump;
      exp = a_act_explore;
      cj = c_act_jump;
      cexp = c_act_explore;
      lf = lfsr_prev;
      tick();
      extra = a_act_valid;
   endtask

   task automatic check_obs(input string name, input int lat,
                            input logic jmp, input logic exp,
                            input logic cj, input logic cexp,
                            input logic [15:0] lf, input logic extra,
                            input logic jmp_req);
      logic ce;
      ce = 8'd255 > lf[7:0];
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL %s_latency: got %0d, required 2", name, lat);
      end
      checks++;
      if (jmp !== jmp_req || exp !== 1'b0) begin
         failures++;
         $display("FAIL %s_decision: jump=%b explore=%b, required %b 0",
                  name, jmp, exp, jmp_req);
      end
      checks++;
      if (extra !== 1'b0) begin
         failures++;
         $display("FAIL %s_pulse: act_valid=%b next cycle, required 0",
                  name, extra);
      end
      checks++;
      if (cexp !== ce || cj !== (ce ? lf[15] : jmp_req)) begin
         failures++;
         $display("FAIL %s_explore: jump=%b explore=%b, required %b %b",
                  name, cj, cexp, ce ? lf[15] : jmp_req, ce);
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (a_busy !== 1'b1 || a_obs_ready !== 1'b0 || a_upd_ready !== 1'b0
          || a_act_valid !== 1'b0 || a_act_jump !== 1'b0
          || a_act_explore !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b ordy=%b urdy=%b av=%b aj=%b ae=%b, required 1 0 0 0 0 0",
                  a_busy, a_obs_ready, a_upd_ready, a_act_valid,
                  a_act_jump, a_act_explore);
      end
      checks++;
      if (a_epsilon !== 8'd0 || b_epsilon !== 8'd2 || c_epsilon !== 8'd255) begin
         failures++;
         $display("FAIL reset_epsilon: got %0d %0d %0d, required 0 2 255",
                  a_epsilon, b_epsilon, c_epsilon);
      end
      reset = 1'b0;
      while (a_busy && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n != 128) begin
         failures++;
         $display("FAIL busy_len: got %0d cycles, required 128", n);
      end
      checks++;
      if (a_obs_ready !== 1'b1 || a_upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_init: ordy=%b urdy=%b, required 1 1",
                  a_obs_ready, a_upd_ready);
      end
      table_all_mid("init_table");
   endtask

   task automatic test_epsilon();
      logic [7:0] ev;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int n = 0; n < 14; n++) begin
         if (n == 0 || n == 3 || n == 4 || n == 7 || n == 8 || n == 13) begin
            ev = (n < 4) ? 8'd2 : (n < 8) ? 8'd1 : 8'd0;
            checks++;
            if (b_epsilon !== ev) begin
               failures++;
               $display("FAIL eps_decay_c%0d: got %0d, required %0d",
                        n, b_epsilon, ev);
            end
         end
         tick();
      end
      wait_idle();
   endtask

   task automatic test_good_update();
      int lat;
      logic j, e, cj, ce, x;
      logic [15:0] lf;
      do_update(10'd45, 2'd2, 1'b1, 1'b1);
      checks++;
      if (dut_a.qtab[6] !== {8'd159, 8'd128}) begin
         failures++;
         $display("FAIL good_update_q: got %h, required 9f80", dut_a.qtab[6]);
      end
      do_observe(10'd50, 2'd2, lat, j, e, cj, ce, lf, x);
      check_obs("obs_good", lat, j, e, cj, ce, lf, x, 1'b1);
   endtask

   task automatic test_bad_update();
      int lat;
      logic j, e, cj, ce, x;
      logic [15:0] lf;
      logic [7:0] exp_q [4] = '{96, 72, 54, 41};
      for (int i = 0; i < 4; i++) begin
         do_update(10'd0, 2'd0, 1'b1, 1'b0);
         checks++;
         if (dut_a.qtab[0] !== {exp_q[i], 8'd128}) begin
            failures++;
            $display("FAIL bad_update_%0d: got %h, required %h80",
                     i, dut_a.qtab[0], exp_q[i]);
         end
      end
      do_observe(10'd0, 2'd0, lat, j, e, cj, ce, lf, x);
      check_obs("obs_bad", lat, j, e, cj, ce, lf, x, 1'b0);
      do_observe(10'd100, 2'd1, lat, j, e, cj, ce, lf, x);
      check_obs("obs_tie", lat, j, e, cj, ce, lf, x, 1'b0);
   endtask

   task automatic test_clamp();
      int bad = 0;
      int lat;
      logic j, e, cj, ce, x;
      logic [15:0] lf;
      do_update(10'd1023, 2'd3, 1'b0, 1'b1);
      checks++;
      if (dut_a.qtab[127] !== {8'd128, 8'd159}) begin
         failures++;
         $display("FAIL clamp_q: got %h, required 809f", dut_a.qtab[127]);
      end
      for (int i = 0; i < 128; i++)
         if (i != 0 && i != 6 && i != 127 && dut_a.qtab[i] !== 16'h8080)
            bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL clamp_others: %0d entries changed, required 0", bad);
      end
      do_observe(10'd1023, 2'd3, lat, j, e, cj, ce, lf, x);
      check_obs("obs_clamp", lat, j, e, cj, ce, lf, x, 1'b0);
   endtask

   task automatic test_fixed_point();
      for (int i = 0; i < 12; i++) begin
         do_update(10'd5, 2'd0, 1'b1, 1'b0);
         checks++;
         if (dut_a.qtab[0][15:8] !== bad_exp[i]) begin
            failures++;
            $display("FAIL bad_chain_%0d: got %0d, required %0d",
                     i, dut_a.qtab[0][15:8], bad_exp[i]);
         end
      end
      for (int i = 0; i < 15; i++) begin
         do_update(10'd1000, 2'd3, 1'b0, 1'b1);
         checks++;
         if (dut_a.qtab[127][7:0] !== good_exp[i]) begin
            failures++;
            $display("FAIL good_chain_%0d: got %0d, required %0d",
                     i, dut_a.qtab[127][7:0], good_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int k = 0;
      int lat = 0;
      upd_valid = 1'b1;
      upd_distance = 10'd200;
      upd_type = 2'd1;
      upd_action = 1'b1;
      upd_good = 1'b1;
      obs_valid = 1'b1;
      obs_distance = 10'd200;
      obs_type = 2'd1;
      #1;
      checks++;
      if (a_obs_ready !== 1'b0 || a_upd_ready !== 1'b1) begin
         failures++;
         $display("FAIL collide_ready: ordy=%b urdy=%b, required 0 1",
                  a_obs_ready, a_upd_ready);
      end
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      while (!a_obs_ready && k < 10) begin
         tick();
         k++;
      end
      checks++;
      if (k + 1 != 3) begin
         failures++;
         $display("FAIL collide_obs_delay: got %0d, required 3", k + 1);
      end
      tick();
      obs_valid = 1'b0;
      while (!a_act_valid && lat < 10) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 2 || a_act_jump !== 1'b1) begin
         failures++;
         $display("FAIL collide_decision: lat=%0d jump=%b, required 2 1",
                  lat, a_act_jump);
      end
      checks++;
      if (dut_a.qtab[25] !== {8'd159, 8'd128}) begin
         failures++;
         $display("FAIL collide_q: got %h, required 9f80", dut_a.qtab[25]);
      end
      tick();
   endtask

   task automatic test_reset_abort();
      logic seen = 1'b0;
      upd_valid = 1'b1;
      upd_distance = 10'd0;
      upd_type = 2'd0;
      upd_action = 1'b1;
      upd_good = 1'b1;
      tick();
      upd_valid = 1'b0;
      reset = 1'b1;
      tick();
      checks++;
      if (a_busy !== 1'b1 || a_upd_ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_busy: busy=%b urdy=%b, required 1 0",
                  a_busy, a_upd_ready);
      end
      tick();
      checks++;
      if (dut_a.qtab[0] !== {8'd3, 8'd128}) begin
         failures++;
         $display("FAIL abort_no_write: got %h, required 0380", dut_a.qtab[0]);
      end
      reset = 1'b0;
      wait_idle();
      obs_valid = 1'b1;
      obs_distance = 10'd10;
      obs_type = 2'd0;
      tick();
      obs_valid = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 2)
            reset = 1'b0;
         tick();
         seen = seen | a_act_valid;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL abort_obs: act_valid=%b seen, required 0", seen);
      end
      wait_idle();
      table_all_mid("abort_table");
   endtask

   initial begin
      test_reset();
      test_epsilon();
      test_good_update();
      test_bad_update();
      test_clamp();
      test_fixed_point();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
